// File: rtl/adder_core.sv
// -----------------------------------------------------------------------------
// adder_core
//   Registered, valid-qualified unsigned adder. An operand pair sampled with
//   valid high produces its full-width sum on c, LATENCY edges after sampling
//   (counting the sampling edge). A one-cycle c_valid strobe marks each new
//   result, and a wrap-around counter tracks the number of results produced.
//
// Ports
//   clk      in   1            rising-edge clock
//   rst      in   1            asynchronous, active-low reset
//   valid    in   1            operand qualifier; a/b ignored when low
//   a        in   WIDTH        unsigned operand A
//   b        in   WIDTH        unsigned operand B
//   c        out  WIDTH+1      registered sum, carry-out in the MSB
//   c_valid  out  1            one-cycle strobe per accepted operand pair
//   txn_cnt  out  CNT_WIDTH    results produced, modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module adder_core #(
  parameter int WIDTH     = 4,
  parameter int LATENCY   = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH:0]       c,
  output logic                 c_valid,
  output logic [CNT_WIDTH-1:0] txn_cnt
);

  // Reject unsupported configurations while elaborating.
  generate
    if ((LATENCY < 1) || (LATENCY > 4) || (WIDTH < 1) || (CNT_WIDTH < 1)) begin : g_bad_param
      $error("adder_core: illegal parameters (LATENCY must be 1..4, WIDTH and CNT_WIDTH >= 1)");
    end
  endgenerate

  // Zero-extended sum; the extra bit makes overflow impossible.
  function automatic logic [WIDTH:0] add_ext(input logic [WIDTH-1:0] op_a,
                                             input logic [WIDTH-1:0] op_b);
    return {1'b0, op_a} + {1'b0, op_b};
  endfunction

  // Stage k holds the result after k+1 edges; the last stage drives the outputs.
  logic [LATENCY-1:0]   vld_q;
  logic [LATENCY-1:0]   vld_d;
  logic [WIDTH:0]       dat_q [LATENCY];
  logic [WIDTH:0]       dat_d [LATENCY];
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Next-state for the pipeline and the transaction counter.
  always_comb begin
    vld_d    = vld_q;
    cnt_d    = cnt_q;
    for (int k = 0; k < LATENCY; k++) begin
      dat_d[k] = dat_q[k];
    end

    // First stage: capture the sum only when the operands are qualified, so
    // don't-care (possibly X) operands never enter the pipeline.
    vld_d[0] = valid;
    if (valid) begin
      dat_d[0] = add_ext(a, b);
    end else begin
      dat_d[0] = dat_q[0];
    end

    // Later stages move data forward only behind a valid bit; otherwise each
    // stage holds, which keeps the last result on c while idle.
    for (int k = 1; k < LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) begin
        dat_d[k] = dat_q[k-1];
      end else begin
        dat_d[k] = dat_q[k];
      end
    end

    // Count on the same edge the output strobe rises so txn_cnt and c_valid
    // become visible together.
    if (vld_d[LATENCY-1]) begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline and counter registers; reset discards every in-flight operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= {LATENCY{1'b0}};
      cnt_q <= {CNT_WIDTH{1'b0}};
      for (int k = 0; k < LATENCY; k++) begin
        dat_q[k] <= {(WIDTH+1){1'b0}};
      end
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      for (int k = 0; k < LATENCY; k++) begin
        dat_q[k] <= dat_d[k];
      end
    end
  end

  // Outputs come straight from flops: no combinational input-to-output path.
  assign c       = dat_q[LATENCY-1];
  assign c_valid = vld_q[LATENCY-1];
  assign txn_cnt = cnt_q;

endmodule

// File: tb/tb_adder_core.sv
module tb_adder_core;

  logic       clk;
  // LATENCY=1 instance
  logic       rst1;
  logic       v1;
  logic [3:0] a1;
  logic [3:0] b1;
  logic [4:0] c1;
  logic       cv1;
  logic [7:0] cnt1;
  // LATENCY=3 instance
  logic       rst3;
  logic       v3;
  logic [3:0] a3;
  logic [3:0] b3;
  logic [4:0] c3;
  logic       cv3;
  logic [7:0] cnt3;

  int checks;
  int failures;

  adder_core #(.WIDTH(4), .LATENCY(1), .CNT_WIDTH(8)) u_lat1 (
    .clk(clk), .rst(rst1), .valid(v1), .a(a1), .b(b1),
    .c(c1), .c_valid(cv1), .txn_cnt(cnt1)
  );

  adder_core #(.WIDTH(4), .LATENCY(3), .CNT_WIDTH(8)) u_lat3 (
    .clk(clk), .rst(rst3), .valid(v3), .a(a3), .b(b3),
    .c(c3), .c_valid(cv3), .txn_cnt(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] c;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic [4:0] ec, input logic ecv, input logic [7:0] ecnt);
    check({name, ".c"}, {27'd0, c1}, {27'd0, ec});
    check({name, ".c_valid"}, {31'd0, cv1}, {31'd0, ecv});
    check({name, ".txn_cnt"}, {24'd0, cnt1}, {24'd0, ecnt});
  endtask

  task automatic chk3(input string name, input logic [4:0] ec, input logic ecv, input logic [7:0] ecnt);
    check({name, ".c"}, {27'd0, c3}, {27'd0, ec});
    check({name, ".c_valid"}, {31'd0, cv3}, {31'd0, ecv});
    check({name, ".txn_cnt"}, {24'd0, cnt3}, {24'd0, ecnt});
  endtask

  initial begin
    logic [7:0] exp_cnt;
    logic [4:0] last_c;
    checks   = 0;
    failures = 0;

    vecs[0] = '{a: 4'd3,  b: 4'd5,  c: 5'd8};
    vecs[1] = '{a: 4'd15, b: 4'd15, c: 5'd30};
    vecs[2] = '{a: 4'd15, b: 4'd1,  c: 5'd16};
    vecs[3] = '{a: 4'd0,  b: 4'd0,  c: 5'd0};
    vecs[4] = '{a: 4'd1,  b: 4'd2,  c: 5'd3};
    vecs[5] = '{a: 4'd4,  b: 4'd4,  c: 5'd8};
    vecs[6] = '{a: 4'd9,  b: 4'd8,  c: 5'd17};
    vecs[7] = '{a: 4'd7,  b: 4'd8,  c: 5'd15};
    vecs[8] = '{a: 4'd10, b: 4'd6,  c: 5'd16};

    // ---- reset held with valid operands present ----
    rst1 = 1'b0; rst3 = 1'b0;
    v1 = 1'b1; a1 = 4'd7; b1 = 4'd9;
    v3 = 1'b1; a3 = 4'd7; b3 = 4'd9;
    #2;
    chk1("rst_async1", 5'd0, 1'b0, 8'd0);
    chk3("rst_async3", 5'd0, 1'b0, 8'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk1("rst_hold1", 5'd0, 1'b0, 8'd0);
      chk3("rst_hold3", 5'd0, 1'b0, 8'd0);
    end
    v1 = 1'b0; v3 = 1'b0;
    rst1 = 1'b1;

    // ---- basic add, then hold while idle with X operands ----
    step();
    chk1("idle_after_rst", 5'd0, 1'b0, 8'd0);
    v1 = 1'b1; a1 = 4'd3; b1 = 4'd5;
    step();
    chk1("basic", 5'd8, 1'b1, 8'd1);
    v1 = 1'b0; a1 = 4'bxxxx; b1 = 4'bxxxx;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("hold", 5'd8, 1'b0, 8'd1);
    end

    // ---- table of back-to-back vectors ----
    exp_cnt = 8'd1;
    for (int i = 0; i < 9; i++) begin
      v1 = 1'b1; a1 = vecs[i].a; b1 = vecs[i].b;
      step();
      exp_cnt = exp_cnt + 8'd1;
      chk1($sformatf("vec%0d", i), vecs[i].c, 1'b1, exp_cnt);
    end
    v1 = 1'b0; a1 = 4'bxxxx; b1 = 4'bxxxx;
    step();
    chk1("hold_after_vecs", 5'd16, 1'b0, exp_cnt);

    // ---- async reset asserted mid-cycle, no clock edge ----
    #3;
    rst1 = 1'b0;
    #1;
    chk1("rst_midcycle", 5'd0, 1'b0, 8'd0);
    rst1 = 1'b1;

    // ---- LATENCY=3: reset while an operation is in flight ----
    rst3 = 1'b1;
    step();
    v3 = 1'b1; a3 = 4'd2; b3 = 4'd2;
    step();
    v3 = 1'b0; a3 = 4'bxxxx; b3 = 4'bxxxx;
    chk3("l3_inflight_a", 5'd0, 1'b0, 8'd0);
    step();
    rst3 = 1'b0;
    #1;
    chk3("l3_rst_flight", 5'd0, 1'b0, 8'd0);
    step();
    rst3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk3("l3_no_ghost", 5'd0, 1'b0, 8'd0);
    end
    v3 = 1'b1; a3 = 4'd6; b3 = 4'd1;
    step();
    v3 = 1'b0; a3 = 4'bxxxx; b3 = 4'bxxxx;
    chk3("l3_edge1", 5'd0, 1'b0, 8'd0);
    step();
    chk3("l3_edge2", 5'd0, 1'b0, 8'd0);
    step();
    chk3("l3_edge3", 5'd7, 1'b1, 8'd1);
    step();
    chk3("l3_after", 5'd7, 1'b0, 8'd1);

    // ---- LATENCY=3 back-to-back ordering ----
    for (int i = 4; i < 7; i++) begin
      v3 = 1'b1; a3 = vecs[i].a; b3 = vecs[i].b;
      step();
    end
    v3 = 1'b0; a3 = 4'bxxxx; b3 = 4'bxxxx;
    chk3("l3_b2b_pre", 5'd3, 1'b1, 8'd2);
    step();
    chk3("l3_b2b_1", 5'd8, 1'b1, 8'd3);
    step();
    chk3("l3_b2b_2", 5'd17, 1'b1, 8'd4);
    step();
    chk3("l3_b2b_end", 5'd17, 1'b0, 8'd4);

    // ---- counter wrap on LATENCY=1 (counter cleared by mid-cycle reset) ----
    last_c = 5'd0;
    for (int i = 0; i < 256; i++) begin
      v1 = 1'b1;
      a1 = 4'(i);
      b1 = 4'd1;
      last_c = {1'b0, 4'(i)} + 5'd1;
      step();
      if (i == 254) begin
        chk1("wrap_255", last_c, 1'b1, 8'd255);
      end
    end
    chk1("wrap_0", 5'd16, 1'b1, 8'd0);
    v1 = 1'b0; a1 = 4'bxxxx; b1 = 4'bxxxx;
    step();
    chk1("wrap_idle", 5'd16, 1'b0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
